// File: rtl/hub75_fb_arbiter.sv
// hub75_fb_arbiter: round-robin two-port framebuffer write arbiter with frame-synchronised page swap
module hub75_fb_arbiter #(
  parameter int hpixel_p = 64,
  parameter int vpixel_p = 64,
  parameter int bpp_p    = 8,
  localparam int addr_width_p = $clog2(hpixel_p*vpixel_p)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req0_valid,
  input  logic                    i_req1_valid,
  input  logic [addr_width_p-1:0] i_req0_addr,
  input  logic [addr_width_p-1:0] i_req1_addr,
  input  logic [3*bpp_p-1:0]      i_req0_data,
  input  logic [3*bpp_p-1:0]      i_req1_data,
  output logic                    o_req0_ready,
  output logic                    o_req1_ready,
  output logic                    o_wr_en,
  output logic [addr_width_p:0]   o_wr_addr,
  output logic [3*bpp_p-1:0]      o_wr_data,
  input  logic                    i_swap_req,
  input  logic                    i_frame_done,
  output logic                    o_front_page,
  output logic                    o_swap_pending,
  output logic                    o_swap_ack
);
  typedef enum logic {RUN, PEND} state_t;
  state_t state, state_n;
  logic ptr, g0, g1, do_swap;
  always_comb begin
    state_n = state;
    g0 = 1'b0;
    g1 = 1'b0;
    do_swap = 1'b0;
    if (state == RUN) begin
      g0 = ~rst & i_req0_valid & (~i_req1_valid | ~ptr);
      g1 = ~rst & i_req1_valid & (~i_req0_valid | ptr);
      state_n = i_swap_req ? PEND : RUN;
    end else begin
      // a beat still landing this cycle would straddle the swap, so wait a frame
      do_swap = i_frame_done & ~o_wr_en;
      state_n = do_swap ? RUN : PEND;
    end
  end
  assign o_req0_ready = g0;
  assign o_req1_ready = g1;
  assign o_swap_pending = (state == PEND);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else state <= state_n;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
      o_wr_en <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
      o_front_page <= 1'b0;
      o_swap_ack <= 1'b0;
    end else begin
      ptr <= g0 | (~g1 & ptr);
      o_wr_en <= g0 | g1;
      if (g0 | g1) begin
        o_wr_addr <= {~o_front_page, g0 ? i_req0_addr : i_req1_addr};
        o_wr_data <= g0 ? i_req0_data : i_req1_data;
      end
      o_front_page <= o_front_page ^ do_swap;
      o_swap_ack <= do_swap;
    end
  end
endmodule

// File: tb/tb_hub75_fb_arbiter.sv
// tb_hub75_fb_arbiter: table-driven check of arbitration, write path, page swap and async reset
module tb_hub75_fb_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic v0 = 0, v1 = 0, sw = 0, fd = 0;
  logic [11:0] a0 = 0, a1 = 0;
  logic [23:0] d0 = 0, d1 = 0;
  logic r0, r1, en, fr, pd, ak;
  logic [12:0] wa;
  logic [23:0] wd;
  int total = 0, bad = 0;

  hub75_fb_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req0_valid(v0), .i_req1_valid(v1),
    .i_req0_addr(a0), .i_req1_addr(a1),
    .i_req0_data(d0), .i_req1_data(d1),
    .o_req0_ready(r0), .o_req1_ready(r1),
    .o_wr_en(en), .o_wr_addr(wa), .o_wr_data(wd),
    .i_swap_req(sw), .i_frame_done(fd),
    .o_front_page(fr), .o_swap_pending(pd), .o_swap_ack(ak)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v0, v1, sw, fd;
    logic [11:0] a0, a1;
    logic [23:0] d0, d1;
    logic r0, r1, en;
    logic [12:0] wa;
    logic [23:0] wd;
    logic fr, pd, ak;
  } vec_t;
  vec_t vec[16];

  function automatic vec_t mk(logic v0_, logic v1_, logic sw_, logic fd_,
                              logic [11:0] a0_, logic [23:0] d0_, logic [11:0] a1_, logic [23:0] d1_,
                              logic r0_, logic r1_, logic en_, logic [12:0] wa_, logic [23:0] wd_,
                              logic fr_, logic pd_, logic ak_);
    vec_t t;
    t.v0 = v0_; t.v1 = v1_; t.sw = sw_; t.fd = fd_;
    t.a0 = a0_; t.d0 = d0_; t.a1 = a1_; t.d1 = d1_;
    t.r0 = r0_; t.r1 = r1_; t.en = en_; t.wa = wa_; t.wd = wd_;
    t.fr = fr_; t.pd = pd_; t.ak = ak_;
    return t;
  endfunction

  task automatic chk(string n, int i, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got %0h want %0h", n, i, act, exp);
    end
  endtask

  task automatic drive(logic v0_, logic v1_, logic sw_, logic fd_,
                       logic [11:0] a0_, logic [23:0] d0_, logic [11:0] a1_, logic [23:0] d1_);
    v0 = v0_; v1 = v1_; sw = sw_; fd = fd_;
    a0 = a0_; d0 = d0_; a1 = a1_; d1 = d1_;
  endtask

  initial begin
    //               v0 v1 sw fd  a0      d0           a1      d1           r0 r1 en  wa        wd           fr pd ak
    vec[0]  = mk(1, 1, 0, 0, 12'h001, 24'h010101, 12'h002, 24'h020202, 1, 0, 1, 13'h1001, 24'h010101, 0, 0, 0);
    vec[1]  = mk(1, 1, 0, 0, 12'h003, 24'h030303, 12'h004, 24'h040404, 0, 1, 1, 13'h1004, 24'h040404, 0, 0, 0);
    vec[2]  = mk(1, 1, 0, 0, 12'h006, 24'h060606, 12'h007, 24'h070707, 1, 0, 1, 13'h1006, 24'h060606, 0, 0, 0);
    vec[3]  = mk(1, 1, 0, 0, 12'h008, 24'h080808, 12'h009, 24'h090909, 0, 1, 1, 13'h1009, 24'h090909, 0, 0, 0);
    vec[4]  = mk(0, 0, 0, 0, 12'h0AA, 24'h111111, 12'h0BB, 24'h222222, 0, 0, 0, 13'h1009, 24'h090909, 0, 0, 0);
    vec[5]  = mk(1, 0, 0, 0, 12'h005, 24'hFF0000, 12'h0BB, 24'h222222, 1, 0, 1, 13'h1005, 24'hFF0000, 0, 0, 0);
    vec[6]  = mk(0, 1, 0, 0, 12'h0AA, 24'h111111, 12'hFFF, 24'hABCDEF, 0, 1, 1, 13'h1FFF, 24'hABCDEF, 0, 0, 0);
    vec[7]  = mk(1, 0, 0, 1, 12'h00A, 24'h0A0A0A, 12'h0BB, 24'h222222, 1, 0, 1, 13'h100A, 24'h0A0A0A, 0, 0, 0);
    vec[8]  = mk(0, 1, 1, 0, 12'h0AA, 24'h111111, 12'h00B, 24'h0B0B0B, 0, 1, 1, 13'h100B, 24'h0B0B0B, 0, 1, 0);
    vec[9]  = mk(1, 1, 0, 1, 12'h0AA, 24'h111111, 12'h0BB, 24'h222222, 0, 0, 0, 13'h100B, 24'h0B0B0B, 0, 1, 0);
    vec[10] = mk(1, 0, 1, 0, 12'h0AA, 24'h111111, 12'h0BB, 24'h222222, 0, 0, 0, 13'h100B, 24'h0B0B0B, 0, 1, 0);
    vec[11] = mk(0, 0, 0, 1, 12'h0AA, 24'h111111, 12'h0BB, 24'h222222, 0, 0, 0, 13'h100B, 24'h0B0B0B, 1, 0, 1);
    vec[12] = mk(1, 0, 0, 0, 12'h00C, 24'h0C0C0C, 12'h0BB, 24'h222222, 1, 0, 1, 13'h000C, 24'h0C0C0C, 1, 0, 0);
    vec[13] = mk(0, 0, 1, 1, 12'h0AA, 24'h111111, 12'h0BB, 24'h222222, 0, 0, 0, 13'h000C, 24'h0C0C0C, 1, 1, 0);
    vec[14] = mk(0, 0, 0, 1, 12'h0AA, 24'h111111, 12'h0BB, 24'h222222, 0, 0, 0, 13'h000C, 24'h0C0C0C, 0, 0, 1);
    vec[15] = mk(0, 0, 0, 0, 12'h0AA, 24'h111111, 12'h0BB, 24'h222222, 0, 0, 0, 13'h000C, 24'h0C0C0C, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", 0, en, 0); chk("rst_wa", 0, wa, 0); chk("rst_wd", 0, wd, 0);
    chk("rst_fr", 0, fr, 0); chk("rst_pd", 0, pd, 0); chk("rst_ak", 0, ak, 0);
    rst = 1'b0;

    foreach (vec[i]) begin
      drive(vec[i].v0, vec[i].v1, vec[i].sw, vec[i].fd, vec[i].a0, vec[i].d0, vec[i].a1, vec[i].d1);
      #1;
      chk("r0", i, r0, vec[i].r0);
      chk("r1", i, r1, vec[i].r1);
      @(posedge clk);
      #1;
      chk("en", i, en, vec[i].en);
      chk("wa", i, wa, vec[i].wa);
      chk("wd", i, wd, vec[i].wd);
      chk("fr", i, fr, vec[i].fr);
      chk("pd", i, pd, vec[i].pd);
      chk("ak", i, ak, vec[i].ak);
    end

    // flip to page 1, then enter PEND with a beat in flight and reset mid-cycle
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("h_fr", 0, fr, 1);
    drive(1, 0, 1, 0, 12'h021, 24'h123456, 0, 0);
    #1;
    chk("h_r0", 0, r0, 1);
    @(posedge clk); #1;
    chk("h_pd", 0, pd, 1);
    chk("h_en", 0, en, 1);
    chk("h_wa", 0, wa, 13'h0021);
    drive(1, 1, 0, 0, 12'h022, 24'h654321, 12'h023, 24'h0F0F0F);
    #1;
    chk("h_r0", 1, r0, 0);
    chk("h_r1", 1, r1, 0);
    #1 rst = 1'b1;
    #1;
    chk("ar_pd", 0, pd, 0); chk("ar_fr", 0, fr, 0); chk("ar_en", 0, en, 0);
    chk("ar_wa", 0, wa, 0); chk("ar_ak", 0, ak, 0);
    @(posedge clk); #1;
    chk("ar_r0", 0, r0, 0); chk("ar_r1", 0, r1, 0);
    rst = 1'b0;
    #1;
    chk("pr_r0", 0, r0, 1); chk("pr_r1", 0, r1, 0);
    @(posedge clk); #1;
    chk("pr_wa", 0, wa, 13'h1022);
    chk("pr_wd", 0, wd, 24'h654321);
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
